// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: I-side and D-side request/response handshakes plus the memory bus.
// The arbiter binds to the slave modport; requesters and the memory model sit on master.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    logic              d_req_valid;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_write, d_req_addr, d_req_wdata, mem_dout,
        output i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
               mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_write, d_req_addr, d_req_wdata, mem_dout,
        input  i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
               mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: serialises I-side and D-side accesses onto one fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed D-over-I priority.
module mem_access_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input logic                clk,
    input logic                reset,
    mem_access_arbiter_if.slave bus_if
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              write_q, write_d;
    logic              owner_q, owner_d;
    logic              idle, access, pick_d, pick_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign pick_d = bus_if.d_req_valid && (!bus_if.i_req_valid || !last_q);
`else
    assign pick_d = bus_if.d_req_valid;
`endif
    assign pick_i = bus_if.i_req_valid && !pick_d;

    // Readys are masked by reset so every output reads 0 while reset is held
    assign idle   = (state_q == IDLE) && !reset;
    assign access = (state_q == ACCESS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        owner_d   = owner_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: if (pick_d || pick_i) begin
                addr_d  = pick_d ? bus_if.d_req_addr : bus_if.i_req_addr;
                wdata_d = pick_d ? bus_if.d_req_wdata : '0;
                write_d = pick_d && bus_if.d_req_write;
                owner_d = pick_d;
                cnt_d   = CW'(MEM_LATENCY - 1);
                state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                last_d  = pick_d;
`endif
            end
            ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    i_rdata_d = (!write_q && !owner_q) ? bus_if.mem_dout : i_rdata_q;
                    d_rdata_d = (!write_q && owner_q) ? bus_if.mem_dout : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            owner_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            owner_q   <= owner_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus_if.i_req_ready  = idle && pick_i;
    assign bus_if.d_req_ready  = idle && pick_d;
    assign bus_if.i_resp_valid = (state_q == RESP) && !owner_q;
    assign bus_if.d_resp_valid = (state_q == RESP) && owner_q;
    assign bus_if.i_resp_data  = i_rdata_q;
    assign bus_if.d_resp_data  = d_rdata_q;
    assign bus_if.mem_addr     = access ? addr_q : '0;
    assign bus_if.mem_din      = access ? wdata_q : '0;
    assign bus_if.mem_read     = access && !write_q;
    assign bus_if.mem_write    = access && write_q && (cnt_q == '0);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Instance a uses MEM_LATENCY=2, instance b uses MEM_LATENCY=1.
module tb_mem_access_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_a = 0;

    mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a();
    mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b();

    logic [31:0]  mem_a [0:255];
    logic [31:0]  mem_b [0:255];
    logic [133:0] outs_a, outs_b;

    always #5 clk = ~clk;

    assign a.mem_dout = mem_a[a.mem_addr[9:2]];
    assign b.mem_dout = mem_b[b.mem_addr[9:2]];
    assign outs_a = {a.i_req_ready, a.i_resp_valid, a.i_resp_data, a.d_req_ready, a.d_resp_valid,
                     a.d_resp_data, a.mem_addr, a.mem_din, a.mem_read, a.mem_write};
    assign outs_b = {b.i_req_ready, b.i_resp_valid, b.i_resp_data, b.d_req_ready, b.d_resp_valid,
                     b.d_resp_data, b.mem_addr, b.mem_din, b.mem_read, b.mem_write};

    always @(posedge clk) begin
        if (a.mem_write) begin
            mem_a[a.mem_addr[9:2]] <= a.mem_din;
            wr_a <= wr_a + 1;
        end
        if (b.mem_write) mem_b[b.mem_addr[9:2]] <= b.mem_din;
    end

    mem_access_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_a (.clk(clk), .reset(reset), .bus_if(a.slave));
    mem_access_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_b (.clk(clk), .reset(reset), .bus_if(b.slave));

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        a.i_req_valid = 0; a.i_req_addr = 0; a.d_req_valid = 0; a.d_req_write = 0; a.d_req_addr = 0; a.d_req_wdata = 0;
        b.i_req_valid = 0; b.i_req_addr = 0; b.d_req_valid = 0; b.d_req_write = 0; b.d_req_addr = 0; b.d_req_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #1;
        checks++; if (outs_a !== '0) begin errors++; $display("FAIL reset_outs_a: got %h expected 0", outs_a); end
        checks++; if (outs_b !== '0) begin errors++; $display("FAIL reset_outs_b: got %h expected 0", outs_b); end
        tick();
        reset = 0;
        #1;
        checks++; if (outs_a !== '0) begin errors++; $display("FAIL idle_outs_a: got %h expected 0", outs_a); end
    endtask

    task automatic test_iread();
        mem_a[16] = 32'hDEADBEEF;
        a.i_req_valid = 1; a.i_req_addr = 32'h40;
        #1;
        checks++; if ({a.i_req_ready, a.d_req_ready} !== 2'b10) begin errors++; $display("FAIL iread_ready: got %b expected 10", {a.i_req_ready, a.d_req_ready}); end
        tick();
        a.i_req_valid = 0;
        #1;
        checks++; if ({a.mem_read, a.mem_write, a.mem_addr, a.i_req_ready} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
            errors++; $display("FAIL iread_access: got rd=%b wr=%b addr=%h rdy=%b expected rd=1 wr=0 addr=40 rdy=0", a.mem_read, a.mem_write, a.mem_addr, a.i_req_ready);
        end
        tick();
        checks++; if (a.i_resp_valid !== 1'b0) begin errors++; $display("FAIL iread_early: got i_resp_valid=%b expected 0", a.i_resp_valid); end
        tick();
        checks++; if ({a.i_resp_valid, a.d_resp_valid, a.i_resp_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL iread_resp: got iv=%b dv=%b data=%h expected iv=1 dv=0 data=deadbeef", a.i_resp_valid, a.d_resp_valid, a.i_resp_data);
        end
        tick();
        checks++; if ({a.i_resp_valid, a.i_resp_data, a.mem_read} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL iread_hold: got iv=%b data=%h rd=%b expected iv=0 data=deadbeef rd=0", a.i_resp_valid, a.i_resp_data, a.mem_read);
        end
    endtask

    task automatic test_store_load();
        int w0;
        w0 = wr_a;
        a.d_req_valid = 1; a.d_req_write = 1; a.d_req_addr = 32'h100; a.d_req_wdata = 32'h12345678;
        #1;
        checks++; if (a.d_req_ready !== 1'b1) begin errors++; $display("FAIL store_ready: got %b expected 1", a.d_req_ready); end
        tick();
        a.d_req_valid = 0;
        tick();
        tick();
        checks++; if ({a.d_resp_valid, a.i_resp_valid, a.d_resp_data} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL store_resp: got dv=%b iv=%b data=%h expected dv=1 iv=0 data=0", a.d_resp_valid, a.i_resp_valid, a.d_resp_data);
        end
        tick();
        checks++; if (wr_a - w0 !== 1 || mem_a[64] !== 32'h12345678) begin
            errors++; $display("FAIL store_commit: got writes=%0d mem=%h expected writes=1 mem=12345678", wr_a - w0, mem_a[64]);
        end
        a.d_req_valid = 1; a.d_req_write = 0;
        #1;
        tick();
        a.d_req_valid = 0;
        tick();
        tick();
        checks++; if ({a.d_resp_valid, a.d_resp_data} !== {1'b1, 32'h12345678}) begin
            errors++; $display("FAIL load_resp: got dv=%b data=%h expected dv=1 data=12345678", a.d_resp_valid, a.d_resp_data);
        end
        tick();
    endtask

    task automatic test_both_valid();
        int n;
        a.i_req_valid = 1; a.i_req_addr = 32'h40;
        a.d_req_valid = 1; a.d_req_write = 0; a.d_req_addr = 32'h100;
        #1;
        checks++; if ({a.d_req_ready, a.i_req_ready} !== 2'b10) begin errors++; $display("FAIL both_first: got d/i=%b expected 10", {a.d_req_ready, a.i_req_ready}); end
        tick();
        a.d_req_valid = 0;
        n = 0;
        while (!a.i_req_ready && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== LAT + 1) begin errors++; $display("FAIL both_second: got i grant after %0d cycles expected %0d", n + 1, LAT + 2); end
        tick();
        a.i_req_valid = 0;
        for (int k = 0; k < LAT; k++) tick();
        checks++; if ({a.i_resp_valid, a.i_resp_data} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL both_iresp: got iv=%b data=%h expected iv=1 data=deadbeef", a.i_resp_valid, a.i_resp_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int  g;
        bit  exp_d;
        reset = 1;
        tick();
        reset = 0;
        a.i_req_valid = 1; a.i_req_addr = 32'h40;
        a.d_req_valid = 1; a.d_req_write = 0; a.d_req_addr = 32'h100;
        #1;
        g = 0;
        exp_d = 1;
        for (int n = 0; n < 60 && g < 4; n++) begin
            if (a.i_req_ready || a.d_req_ready) begin
                checks++; if ({a.d_req_ready, a.i_req_ready} !== {exp_d, !exp_d}) begin
                    errors++; $display("FAIL rr_grant%0d: got d/i=%b expected %b", g, {a.d_req_ready, a.i_req_ready}, {exp_d, !exp_d});
                end
                exp_d = !exp_d;
                g++;
            end
            tick();
        end
        checks++; if (g !== 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", g); end
        a.i_req_valid = 0; a.d_req_valid = 0;
        for (int k = 0; k < LAT + 2; k++) tick();
    endtask

    task automatic test_reset_mid_store();
        bit seen;
        mem_a[32] = 32'h11111111;
        a.d_req_valid = 1; a.d_req_write = 1; a.d_req_addr = 32'h80; a.d_req_wdata = 32'hCAFEF00D;
        #1;
        tick();
        a.d_req_valid = 0;
        reset = 1;
        a.i_req_valid = 1; a.i_req_addr = 32'h80;
        #1;
        checks++; if (outs_a !== '0) begin errors++; $display("FAIL rst_mid_outs: got %h expected 0", outs_a); end
        tick();
        tick();
        checks++; if (mem_a[32] !== 32'h11111111) begin errors++; $display("FAIL rst_mid_mem: got %h expected 11111111", mem_a[32]); end
        reset = 0;
        a.i_req_valid = 0;
        #1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            seen |= a.i_resp_valid | a.d_resp_valid | a.mem_write;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: got activity=%b expected 0", seen); end
        a.i_req_valid = 1;
        #1;
        checks++; if (a.i_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got i_req_ready=%b expected 1", a.i_req_ready); end
        tick();
        a.i_req_valid = 0;
        for (int k = 0; k < LAT; k++) tick();
        checks++; if ({a.i_resp_valid, a.i_resp_data} !== {1'b1, 32'h11111111}) begin
            errors++; $display("FAIL rst_mid_read: got iv=%b data=%h expected iv=1 data=11111111", a.i_resp_valid, a.i_resp_data);
        end
        tick();
    endtask

    task automatic test_lat1_stream();
        int          last_c, grants;
        logic [31:0] hs_q[$];
        logic [31:0] rd_q[$];
        logic [31:0] ad;
        for (int k = 0; k < 16; k++) mem_b[k] = 32'hB0000000 + k;
        last_c = -1;
        grants = 0;
        b.i_req_valid = 1; b.i_req_addr = 0;
        #1;
        for (int n = 0; n < 40 && grants < 5; n++) begin
            if (b.mem_read && hs_q.size() > 0) begin
                ad = hs_q.pop_front();
                checks++; if (b.mem_addr !== ad) begin errors++; $display("FAIL lat1_addr: got %h expected %h", b.mem_addr, ad); end
                rd_q.push_back(ad);
            end
            if (b.i_resp_valid && rd_q.size() > 0) begin
                ad = rd_q.pop_front();
                checks++; if (b.i_resp_data !== 32'hB0000000 + (ad >> 2)) begin
                    errors++; $display("FAIL lat1_data: got %h expected %h", b.i_resp_data, 32'hB0000000 + (ad >> 2));
                end
            end
            if (b.i_req_ready) begin
                if (last_c >= 0) begin
                    checks++; if (cyc - last_c !== 3) begin errors++; $display("FAIL lat1_period: got %0d expected 3", cyc - last_c); end
                end
                last_c = cyc;
                grants++;
                hs_q.push_back(b.i_req_addr);
                tick();
                b.i_req_addr += 4;
                #1;
            end else begin
                tick();
            end
        end
        checks++; if (grants !== 5) begin errors++; $display("FAIL lat1_grants: got %0d expected 5", grants); end
        b.i_req_valid = 0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_random(input int n);
        logic [31:0] refm [0:255];
        int          busy_until, resp_at, idx;
        bit          r_side, r_write, last_d, pd, pi, hi, hd;
        logic [31:0] r_data, ei, ed;
        logic [4:0]  got, exp;
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = $urandom;
            refm[k] = mem_a[k];
        end
        busy_until = 0; resp_at = -10; r_side = 0; r_write = 0; r_data = 0;
        ei = 0; ed = 0; last_d = 0;
        for (int k = 0; k < n; k++) begin
            if (!a.i_req_valid && $urandom_range(0, 2) == 0) begin
                a.i_req_valid = 1; a.i_req_addr = $urandom_range(0, 15) * 4;
            end
            if (!a.d_req_valid && $urandom_range(0, 2) == 0) begin
                a.d_req_valid = 1; a.d_req_write = 1'($urandom_range(0, 1));
                a.d_req_addr = $urandom_range(0, 15) * 4; a.d_req_wdata = $urandom;
            end
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            pd = a.d_req_valid && (!a.i_req_valid || !last_d);
`else
            pd = a.d_req_valid;
`endif
            pi = a.i_req_valid && !pd;
            hi = (cyc >= busy_until) && pi;
            hd = (cyc >= busy_until) && pd;
            if (cyc == resp_at) begin
                if (!r_side) ei = r_data;
                if (r_side && !r_write) ed = r_data;
            end
            exp = {hi, hd, cyc == resp_at && !r_side, cyc == resp_at && r_side, cyc == resp_at - 1 && r_write};
            got = {a.i_req_ready, a.d_req_ready, a.i_resp_valid, a.d_resp_valid, a.mem_write};
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_ctrl@%0d: got ir/dr/iv/dv/wr=%b expected %b", cyc, got, exp); end
            checks++; if ({a.i_resp_data, a.d_resp_data} !== {ei, ed}) begin
                errors++; $display("FAIL rand_data@%0d: got i=%h d=%h expected i=%h d=%h", cyc, a.i_resp_data, a.d_resp_data, ei, ed);
            end
            if (hi || hd) begin
                r_side = hd;
                r_write = hd && a.d_req_write;
                idx = hd ? int'(a.d_req_addr[9:2]) : int'(a.i_req_addr[9:2]);
                r_data = refm[idx];
                if (r_write) refm[idx] = a.d_req_wdata;
                resp_at = cyc + 1 + LAT;
                busy_until = cyc + 2 + LAT;
                last_d = hd;
            end
            tick();
            if (hi) a.i_req_valid = 0;
            if (hd) a.d_req_valid = 0;
        end
        a.i_req_valid = 0; a.d_req_valid = 0;
        for (int k = 0; k < LAT + 3; k++) tick();
        idx = -1;
        for (int k = 0; k < 256; k++) if (idx < 0 && mem_a[k] !== refm[k]) idx = k;
        checks++; if (idx >= 0) begin errors++; $display("FAIL rand_mem: word %0d got %h expected %h", idx, mem_a[idx], refm[idx]); end
    endtask

    initial begin
        test_reset();
        test_iread();
        test_store_load();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_both_valid();
`endif
        test_reset_mid_store();
        test_lat1_stream();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end
endmodule
